// File: rtl/zx_pkg.sv
// ---------------------------------------------------------------------------
// zx_pkg
//   Shared definitions for the Spectrum memory pager:
//   - I/O port addresses of the paging registers (7FFD, 1FFD)
//   - 16K page geometry
//   - CPU slot enum (one 16K window per A[15:14] value)
//   - port-latch FSM state enum
//   - helpers that decode a committed 7FFD value into a RAM page index,
//     and the +3 all-RAM ("special") page table
// ---------------------------------------------------------------------------
package zx_pkg;

  localparam logic [15:0] PORT_7FFD  = 16'h7FFD;
  localparam logic [15:0] PORT_1FFD  = 16'h1FFD;

  localparam int unsigned PAGE_SIZE  = 16384;
  localparam int unsigned PAGE_OFF_W = 14;     // log2(PAGE_SIZE)

  // One CPU slot per A[15:14].
  typedef enum logic [1:0] {
    SLOT_0000 = 2'd0,
    SLOT_4000 = 2'd1,
    SLOT_8000 = 2'd2,
    SLOT_C000 = 2'd3
  } slot_e;

  typedef enum logic {
    LATCH_IDLE = 1'b0,
    LATCH_CAPT = 1'b1
  } latch_state_e;

  // Full 5-bit page index carried by a 7FFD value: D[7] and D[6] extend the
  // classic D[2:0]; the top keeps only as many bits as it is configured for.
  function automatic logic [4:0] page_from_7ffd(input logic [7:0] v);
    return {v[7], v[6], v[2:0]};
  endfunction

  // +3 special (all-RAM) configurations:
  //   cfg 0: {0,1,2,3}  cfg 1: {4,5,6,7}  cfg 2: {4,5,6,3}  cfg 3: {4,7,6,3}
  // listed from slot 0000 to slot C000.
  function automatic logic [2:0] special_page(input logic [1:0] cfg,
                                              input logic [1:0] slot);
    logic [11:0] row;   // {C000, 8000, 4000, 0000}
    row = '0;
    case (cfg)
      2'd0:    row = {3'd3, 3'd2, 3'd1, 3'd0};
      2'd1:    row = {3'd7, 3'd6, 3'd5, 3'd4};
      2'd2:    row = {3'd3, 3'd6, 3'd5, 3'd4};
      default: row = {3'd3, 3'd6, 3'd7, 3'd4};
    endcase
    return row[slot*3 +: 3];
  endfunction

endpackage

// File: rtl/zx_port_latch.sv
// ---------------------------------------------------------------------------
// zx_port_latch
//   Capture/commit FSM for one paging I/O port. The value on the data bus is
//   captured on the first clock of a selected, unlocked I/O write and only
//   committed once the write strobe goes away, so a long write cycle commits
//   exactly once and the new mapping never appears mid-cycle.
//
// Parameters
//   W       register width
// Ports
//   clk     in   1   system clock
//   rst_n   in   1   asynchronous active-low reset (drops any pending capture)
//   io_we   in   1   qualified I/O write strobe
//   sel     in   1   this port is addressed
//   locked  in   1   paging lock; blocks new captures
//   d       in   W   CPU write data
//   value   out  W   committed register value
// ---------------------------------------------------------------------------
module zx_port_latch
  import zx_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         io_we,
  input  logic         sel,
  input  logic         locked,
  input  logic [W-1:0] d,
  output logic [W-1:0] value
);

  latch_state_e state_q, state_d;
  logic [W-1:0] cap_q,   cap_d;
  logic [W-1:0] value_q, value_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    cap_d   = cap_q;
    value_d = value_q;
    case (state_q)
      LATCH_IDLE: begin
        if (io_we && sel && !locked) begin
          state_d = LATCH_CAPT;
          cap_d   = d;
        end
      end
      LATCH_CAPT: begin
        if (!io_we) begin
          state_d = LATCH_IDLE;
          value_d = cap_q;
        end
      end
      default: state_d = LATCH_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LATCH_IDLE;
      cap_q   <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/zx_mem_pager.sv
// ---------------------------------------------------------------------------
// zx_mem_pager
//   Spectrum 128K..512K memory mapper. Decodes paging port writes, holds the
//   paging state and maps every Z80 memory access onto a flat SDRAM address,
//   with ROM write protection and a screen-RAM mirror strobe for vram.
//
// Configuration macro
//   PAGER_PLUS3_EN  decode 1FFD (ROM high bit, +3 all-RAM special modes) and
//                   narrow the 7FFD decode to A[15:14]==01.
//
// Parameters
//   RAM_PAGE_BITS  RAM page index width (3..5): 128K / 256K / 512K
//   ADDR_W         SDRAM byte address width
//   RAM_BASE       SDRAM address of RAM page 0
//   ROM_BASE       SDRAM address of ROM bank 0
// Ports
//   clk_sys      in   system clock
//   nRESET       in   asynchronous active-low reset
//   A, D         in   CPU address / write data
//   nMREQ..nM1   in   Z80 strobes, active low
//   mem_addr     out  flat SDRAM address of the current access
//   mem_rom      out  current slot maps ROM
//   mem_we_ok    out  memory write permitted
//   vram_we      out  write hits screen area of page 5 or 7
//   vram_addr    out  {page==7, A[12:0]}
//   shadow_scr   out  video screen select (7FFD bit 3)
//   ram_page     out  page mapped at C000
//   rom_bank     out  ROM bank at 0000
//   page_locked  out  7FFD bit 5; paging writes ignored until reset
// ---------------------------------------------------------------------------
module zx_mem_pager
  import zx_pkg::*;
#(
  parameter int unsigned     RAM_PAGE_BITS = 3,
  parameter int unsigned     ADDR_W        = 25,
  parameter logic [ADDR_W-1:0] RAM_BASE    = '0,
  parameter logic [ADDR_W-1:0] ROM_BASE    = '0
) (
  input  logic                     clk_sys,
  input  logic                     nRESET,
  input  logic [15:0]              A,
  input  logic [7:0]               D,
  input  logic                     nMREQ,
  input  logic                     nIORQ,
  input  logic                     nRD,
  input  logic                     nWR,
  input  logic                     nM1,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_rom,
  output logic                     mem_we_ok,
  output logic                     vram_we,
  output logic [13:0]              vram_addr,
  output logic                     shadow_scr,
  output logic [RAM_PAGE_BITS-1:0] ram_page,
  output logic [1:0]               rom_bank,
  output logic                     page_locked
);

  // ---------------- port decode ----------------
  logic       io_we;
  logic       sel_7ffd;
  logic [7:0] reg_7ffd;
  logic [2:0] reg_1ffd;   // [0] special, [2:1] config / ROM high bit

  // Interrupt acknowledge also asserts nIORQ, but with nM1 low; exclude it.
  assign io_we = !nIORQ && !nWR && nRD && nM1;

`ifdef PAGER_PLUS3_EN
  logic sel_1ffd;
  assign sel_7ffd = (A[15:14] == 2'b01) && !A[1];
  assign sel_1ffd = (A[15:12] == 4'b0001) && !A[1];

  zx_port_latch #(.W(3)) u_latch_1ffd (
    .clk    (clk_sys),
    .rst_n  (nRESET),
    .io_we  (io_we),
    .sel    (sel_1ffd),
    .locked (page_locked),
    .d      (D[2:0]),
    .value  (reg_1ffd)
  );
`else
  assign sel_7ffd = !A[15] && !A[1];
  assign reg_1ffd = 3'b000;
`endif

  zx_port_latch #(.W(8)) u_latch_7ffd (
    .clk    (clk_sys),
    .rst_n  (nRESET),
    .io_we  (io_we),
    .sel    (sel_7ffd),
    .locked (page_locked),
    .d      (D),
    .value  (reg_7ffd)
  );

  // ---------------- paging fields ----------------
  logic special_mode;

  assign ram_page     = RAM_PAGE_BITS'(page_from_7ffd(reg_7ffd));
  assign shadow_scr   = reg_7ffd[3];
  assign page_locked  = reg_7ffd[5];
  assign rom_bank     = {reg_1ffd[2], reg_7ffd[4]};
  assign special_mode = reg_1ffd[0];

  // ---------------- address mapping ----------------
  slot_e             slot;
  logic [4:0]        page_idx;
  logic              is_rom;
  logic [ADDR_W-1:0] base;

  always_comb begin
    slot     = slot_e'(A[15:14]);
    is_rom   = 1'b0;
    page_idx = '0;
    if (special_mode) begin
      page_idx = {2'b00, special_page(reg_1ffd[2:1], A[15:14])};
    end else begin
      case (slot)
        SLOT_0000: begin
          is_rom   = 1'b1;
          page_idx = {3'b000, rom_bank};
        end
        SLOT_4000: page_idx = 5'd5;
        SLOT_8000: page_idx = 5'd2;
        default:   page_idx = 5'(ram_page);
      endcase
    end
  end

  assign base      = is_rom ? ROM_BASE : RAM_BASE;
  assign mem_addr  = base + ADDR_W'({page_idx, A[PAGE_OFF_W-1:0]});
  assign mem_rom   = is_rom;
  assign mem_we_ok = !nMREQ && !nWR && !is_rom;

  // Screen area is the low 8K of pages 5 and 7.
  assign vram_we   = !nMREQ && !nWR && nRD && !is_rom &&
                     (page_idx == 5'd5 || page_idx == 5'd7) && !A[13];
  assign vram_addr = {page_idx == 5'd7, A[12:0]};

endmodule

// File: tb/tb_zx_mem_pager.sv
// ---------------------------------------------------------------------------
// tb_zx_mem_pager
//   Directed self-checking bench for zx_mem_pager, built with a 512K page
//   range and non-zero SDRAM bases so address arithmetic is visible.
// ---------------------------------------------------------------------------
module tb_zx_mem_pager;
  import zx_pkg::*;

  localparam int unsigned     RPB      = 5;
  localparam int unsigned     AW       = 25;
  localparam logic [AW-1:0]   RAM_B    = 25'h0100000;
  localparam logic [AW-1:0]   ROM_B    = 25'h0040000;

  logic            clk_sys = 1'b0;
  logic            nRESET;
  logic [15:0]     A;
  logic [7:0]      D;
  logic            nMREQ, nIORQ, nRD, nWR, nM1;
  logic [AW-1:0]   mem_addr;
  logic            mem_rom, mem_we_ok, vram_we;
  logic [13:0]     vram_addr;
  logic            shadow_scr;
  logic [RPB-1:0]  ram_page;
  logic [1:0]      rom_bank;
  logic            page_locked;

  int checks = 0;
  int fails  = 0;

  always #5 clk_sys = ~clk_sys;

  zx_mem_pager #(
    .RAM_PAGE_BITS (RPB),
    .ADDR_W        (AW),
    .RAM_BASE      (RAM_B),
    .ROM_BASE      (ROM_B)
  ) dut (
    .clk_sys     (clk_sys),
    .nRESET      (nRESET),
    .A           (A),
    .D           (D),
    .nMREQ       (nMREQ),
    .nIORQ       (nIORQ),
    .nRD         (nRD),
    .nWR         (nWR),
    .nM1         (nM1),
    .mem_addr    (mem_addr),
    .mem_rom     (mem_rom),
    .mem_we_ok   (mem_we_ok),
    .vram_we     (vram_we),
    .vram_addr   (vram_addr),
    .shadow_scr  (shadow_scr),
    .ram_page    (ram_page),
    .rom_bank    (rom_bank),
    .page_locked (page_locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1;
  endtask

  // Combinational memory access; outputs settle after #1.
  task automatic mem_acc(input logic [15:0] addr, input logic wr);
    A = addr; nIORQ = 1'b1; nMREQ = 1'b0; nRD = wr; nWR = !wr;
    #1;
  endtask

  // Two-clock OUT cycle; returns #1 after the commit edge.
  task automatic io_out(input logic [15:0] port, input logic [7:0] val);
    @(negedge clk_sys);
    bus_idle();
    A = port; D = val; nIORQ = 1'b0; nWR = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    nWR = 1'b1; nIORQ = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  task automatic check_regs(input string tag, input logic [4:0] pg, input logic [1:0] rb,
                            input logic sh, input logic lk);
    check({tag, ".ram_page"},    32'(ram_page),    32'(pg));
    check({tag, ".rom_bank"},    32'(rom_bank),    32'(rb));
    check({tag, ".shadow_scr"},  32'(shadow_scr),  32'(sh));
    check({tag, ".page_locked"}, 32'(page_locked), 32'(lk));
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    nRESET = 1'b0;
    bus_idle();
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    nRESET = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  initial begin
    nRESET = 1'b0; A = '0; D = '0;
    bus_idle();
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    nRESET = 1'b1;
    @(posedge clk_sys); #1;

    // ---- reset state and default map ----
    check_regs("reset", 5'd0, 2'd0, 1'b0, 1'b0);
    mem_acc(16'h0123, 1'b0);
    check("rom_rd.addr", 32'(mem_addr), 32'h0040123);
    check("rom_rd.rom",  32'(mem_rom),  32'd1);
    mem_acc(16'h0123, 1'b1);
    check("rom_wr.we_ok", 32'(mem_we_ok), 32'd0);
    check("rom_wr.vram",  32'(vram_we),   32'd0);
    mem_acc(16'h4000, 1'b0);
    check("p5_rd.addr", 32'(mem_addr), 32'h0114000);
    check("p5_rd.rom",  32'(mem_rom),  32'd0);
    mem_acc(16'h5800, 1'b1);
    check("p5_scr.vram_we",   32'(vram_we),   32'd1);
    check("p5_scr.vram_addr", 32'(vram_addr), 32'h1800);
    check("p5_scr.we_ok",     32'(mem_we_ok), 32'd1);
    mem_acc(16'h7800, 1'b1);
    check("p5_hi8k.vram_we", 32'(vram_we), 32'd0);
    mem_acc(16'h8000, 1'b0);
    check("p2_rd.addr", 32'(mem_addr), 32'h0108000);
    mem_acc(16'hC000, 1'b1);
    check("p0_c000.vram_we", 32'(vram_we), 32'd0);
    bus_idle();

    // ---- OUT 7FFD,0x07: no change while nWR is low ----
    @(negedge clk_sys);
    A = PORT_7FFD; D = 8'h07; nIORQ = 1'b0; nWR = 1'b0;
    @(posedge clk_sys); #1;
    check("mid_write.ram_page", 32'(ram_page), 32'd0);
    @(negedge clk_sys);
    nWR = 1'b1; nIORQ = 1'b1;
    #1;
    check("nwr_rise.ram_page", 32'(ram_page), 32'd0);
    @(posedge clk_sys); #1;
    check_regs("out07", 5'd7, 2'd0, 1'b0, 1'b0);
    mem_acc(16'hC000, 1'b0);
    check("p7_rd.addr", 32'(mem_addr), 32'h011C000);
    mem_acc(16'hC010, 1'b1);
    check("p7_scr.vram_we",   32'(vram_we),   32'd1);
    check("p7_scr.vram_addr", 32'(vram_addr), 32'h2010);
    bus_idle();

    // ---- 512K page bits ----
    io_out(PORT_7FFD, 8'hC3);
    check_regs("outC3", 5'd27, 2'd0, 1'b0, 1'b0);
    mem_acc(16'hC000, 1'b0);
    check("p27_rd.addr", 32'(mem_addr), 32'h016C000);
    bus_idle();
    io_out(PORT_7FFD, 8'h08);
    check_regs("out08", 5'd0, 2'd0, 1'b1, 1'b0);

    // ---- long write: only first-cycle data commits ----
    @(negedge clk_sys);
    A = PORT_7FFD; D = 8'h05; nIORQ = 1'b0; nWR = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    D = 8'h02;
    repeat (5) @(posedge clk_sys);
    #1;
    check("long_hold.ram_page", 32'(ram_page), 32'd0);
    @(negedge clk_sys);
    nWR = 1'b1; nIORQ = 1'b1;
    @(posedge clk_sys); #1;
    check_regs("long_done", 5'd5, 2'd0, 1'b0, 1'b0);

    // ---- reset while a capture is pending ----
    @(negedge clk_sys);
    A = PORT_7FFD; D = 8'h17; nIORQ = 1'b0; nWR = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    nRESET = 1'b0;
    #1;
    check("rst_capt.ram_page", 32'(ram_page), 32'd0);
    nWR = 1'b1; nIORQ = 1'b1;
    #2;
    nRESET = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    check_regs("rst_capt_after", 5'd0, 2'd0, 1'b0, 1'b0);

    // ---- lock ----
    io_out(PORT_7FFD, 8'h30);
    check_regs("lock", 5'd0, 2'd1, 1'b0, 1'b1);
    mem_acc(16'h0000, 1'b0);
    check("rom1_rd.addr", 32'(mem_addr), 32'h0044000);
    bus_idle();
    io_out(PORT_7FFD, 8'h01);
    check_regs("locked_write", 5'd0, 2'd1, 1'b0, 1'b1);

`ifdef PAGER_PLUS3_EN
    // ---- +3 special mode, config 3 ----
    do_reset();
    io_out(PORT_1FFD, 8'h07);
    mem_acc(16'h0000, 1'b0);
    check("sp3_0000.addr", 32'(mem_addr), 32'h0110000);
    check("sp3_0000.rom",  32'(mem_rom),  32'd0);
    mem_acc(16'h4000, 1'b0);
    check("sp3_4000.addr", 32'(mem_addr), 32'h011C000);
    mem_acc(16'hC000, 1'b0);
    check("sp3_c000.addr", 32'(mem_addr), 32'h010C000);
    bus_idle();
`else
    do_reset();
    check_regs("final_reset", 5'd0, 2'd0, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
